// File: rtl/mram_readout_ctrl_if.sv
// rtl/mram_readout_ctrl_if.sv - host, MRAM and shifter signals of the MRAM read-out sequencer
interface mram_readout_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              req;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_word_sel;
  logic              busy;
  logic              done;
  logic              err;
  logic              mram_rd_req;
  logic [ADDR_W-1:0] mram_addr;
  logic              mram_rd_ack;
  logic              ser_en;
  logic              ser_load;
  logic              ser_send;
  logic [1:0]        ser_word_sel;
  logic              bit_valid;

  modport master (
    output req, req_addr, req_word_sel, mram_rd_ack,
    input  busy, done, err, mram_rd_req, mram_addr,
           ser_en, ser_load, ser_send, ser_word_sel, bit_valid
  );

  modport slave (
    input  req, req_addr, req_word_sel, mram_rd_ack,
    output busy, done, err, mram_rd_req, mram_addr,
           ser_en, ser_load, ser_send, ser_word_sel, bit_valid
  );
endinterface

// File: rtl/mram_readout_ctrl.sv
// rtl/mram_readout_ctrl.sv - MRAM read handshake, shifter load and 8/16-bit serial framing
// Optional READ timeout with ERR state is compiled in by defining RDCTRL_TIMEOUT_EN.
module mram_readout_ctrl #(
  parameter int ADDR_W = 10
`ifdef RDCTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input logic                clk,
  input logic                rst_n,
  mram_readout_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_SHIFT,
    S_DONE
`ifdef RDCTRL_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        sel_q;
  logic [3:0]        bit_cnt_q;
  logic [3:0]        last_idx;
  logic              err_q;
  logic              bit_valid_q;
  logic              req_legal;
  logic              req_illegal;

  assign req_legal   = bus.req && (bus.req_word_sel != 2'b00);
  assign req_illegal = bus.req && (bus.req_word_sel == 2'b00);
  // Full word shifts 16 bits, either byte select shifts 8.
  assign last_idx    = (sel_q == 2'b11) ? 4'd15 : 4'd7;

`ifdef RDCTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == S_READ) begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_q <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_legal) state_d = S_READ;
      S_READ: begin
        if (bus.mram_rd_ack) begin
          state_d = S_LOAD;
        end
`ifdef RDCTRL_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_ERR;
        end
`endif
      end
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (bit_cnt_q == last_idx) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
`ifdef RDCTRL_TIMEOUT_EN
      S_ERR:   state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (state_q != S_IDLE);
    bus.ser_en       = (state_q != S_IDLE);
    bus.mram_rd_req  = (state_q == S_READ);
    bus.ser_load     = (state_q == S_LOAD);
    bus.ser_send     = (state_q == S_SHIFT);
    bus.done         = (state_q == S_DONE);
    bus.mram_addr    = addr_q;
    bus.ser_word_sel = sel_q;
    bus.bit_valid    = bit_valid_q;
`ifdef RDCTRL_TIMEOUT_EN
    bus.err          = err_q || (state_q == S_ERR);
`else
    bus.err          = err_q;
`endif
  end

  // Request capture, bit counter and the registered flags that trail the state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      sel_q       <= 2'b00;
      bit_cnt_q   <= 4'd0;
      err_q       <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      err_q       <= (state_q == S_IDLE) && req_illegal;
      bit_valid_q <= (state_q == S_SHIFT);
      if ((state_q == S_IDLE) && req_legal) begin
        addr_q <= bus.req_addr;
        sel_q  <= bus.req_word_sel;
      end
      if (state_q == S_LOAD) begin
        bit_cnt_q <= 4'd0;
      end else if (state_q == S_SHIFT) begin
        bit_cnt_q <= bit_cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mram_readout_ctrl.sv
// tb/tb_mram_readout_ctrl.sv - randomized self-checking bench for mram_readout_ctrl
module tb_mram_readout_ctrl;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mram_readout_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mram_readout_ctrl #(
    .ADDR_W(ADDR_W)
`ifdef RDCTRL_TIMEOUT_EN
    , .TIMEOUT_CYC(4)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mram_data = 16'h0;
  logic [15:0] sreg = 16'h0;
  logic        dout = 1'b0;

  // Parallel-to-serial shifter sitting downstream of the controller, MSB first.
  always @(posedge clk) begin
    if (bus.ser_en && bus.ser_load) begin
      case (bus.ser_word_sel)
        2'b01:   sreg <= {mram_data[7:0], 8'h00};
        2'b10:   sreg <= {mram_data[15:8], 8'h00};
        default: sreg <= mram_data;
      endcase
    end else if (bus.ser_en && bus.ser_send) begin
      dout <= sreg[15];
      sreg <= {sreg[14:0], 1'b0};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_bits(input logic [1:0] sel, input logic [15:0] word);
    if (sel == 2'b11) return word;
    if (sel == 2'b01) return {8'h00, word[7:0]};
    return {8'h00, word[15:8]};
  endfunction

  // Starts at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
  task automatic run_frame(input logic [1:0] sel, input logic [ADDR_W-1:0] addr,
                           input logic [15:0] word, input int wait_cyc, input bit stray_req);
    int n, k, rd_cyc, sends, valids, loads, done_k, ack_left;
    logic [15:0] bits;
    bit addr_ok;
    n = (sel == 2'b11) ? 16 : 8;
    mram_data = word;
    bus.req = 1'b1;
    bus.req_addr = addr;
    bus.req_word_sel = sel;
    @(negedge clk);
    bus.req = 1'b0;
    bus.req_word_sel = 2'($urandom);
    if (sel == 2'b00) begin
      check("illegal_err", 32'(bus.err), 32'd1);
      check("illegal_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("illegal_err_clear", 32'(bus.err), 32'd0);
      return;
    end
    check("accept_busy", 32'(bus.busy), 32'd1);
    k = 1; rd_cyc = 0; sends = 0; valids = 0; loads = 0; done_k = -1; ack_left = 0;
    bits = 16'h0; addr_ok = 1'b1;
    while (done_k < 0 && k < 200) begin
      if (bus.mram_rd_req) rd_cyc++;
      if (bus.ser_send) sends++;
      if (bus.ser_load) loads++;
      if (bus.bit_valid) begin
        valids++;
        bits = {bits[14:0], dout};
      end
      if (bus.busy && bus.mram_addr !== addr) addr_ok = 1'b0;
      if (bus.done) done_k = k;
      if (bus.mram_rd_req && rd_cyc == wait_cyc + 1) ack_left = 2;
      bus.mram_rd_ack = (ack_left > 0);
      if (ack_left > 0) ack_left--;
      bus.req = stray_req && (k == 3);
      bus.req_addr = ~addr;
      bus.req_word_sel = 2'b11;
      @(negedge clk);
      k++;
    end
    bus.req = 1'b0;
    bus.mram_rd_ack = 1'b0;
    check("idle_after_done", 32'(bus.busy), 32'd0);
    check("read_cycles", rd_cyc, wait_cyc + 1);
    check("load_count", loads, 1);
    check("send_count", sends, n);
    check("valid_count", valids, n);
    check("serial_bits", 32'(bits), 32'(exp_bits(sel, word)));
    check("done_latency", done_k, wait_cyc + 3 + n);
    check("addr_stable", 32'(addr_ok), 32'd1);
  endtask

  initial begin
    int sends, k;
    bus.req = 1'b0;
    bus.req_addr = '0;
    bus.req_word_sel = 2'b00;
    bus.mram_rd_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd_req", 32'(bus.mram_rd_req), 32'd0);
    check("rst_addr", 32'(bus.mram_addr), 32'd0);
    check("rst_ser", 32'({bus.ser_en, bus.ser_load, bus.ser_send, bus.ser_word_sel}), 32'd0);
    check("rst_flags", 32'({bus.done, bus.err, bus.bit_valid}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(2'b11, 10'h005, 16'hA5C3, 2, 1'b0);
    run_frame(2'b01, 10'h0F0, 16'h12F0, 0, 1'b0);
    run_frame(2'b10, 10'h3FF, 16'h12F0, 1, 1'b1);
    run_frame(2'b00, 10'h011, 16'h0000, 0, 1'b0);
    run_frame(2'b11, 10'h2A5, 16'h8001, 0, 1'b1);
    run_frame(2'b01, 10'h15A, 16'hFF7E, 0, 1'b0);

    // Reset in the middle of the shift phase.
    mram_data = 16'hBEEF;
    bus.req = 1'b1;
    bus.req_addr = 10'h123;
    bus.req_word_sel = 2'b11;
    sends = 0;
    k = 0;
    while (sends < 5 && k < 50) begin
      @(negedge clk);
      bus.req = 1'b0;
      bus.mram_rd_ack = bus.mram_rd_req;
      if (bus.ser_send) sends++;
      k++;
    end
    check("mid_reset_reached", sends, 5);
    rst_n = 1'b0;
    bus.mram_rd_ack = 1'b0;
    #1;
    check("mid_reset_busy", 32'({bus.busy, bus.ser_en, bus.mram_rd_req}), 32'd0);
    check("mid_reset_ser", 32'({bus.ser_load, bus.ser_send, bus.ser_word_sel}), 32'd0);
    check("mid_reset_flags", 32'({bus.done, bus.err, bus.bit_valid}), 32'd0);
    check("mid_reset_addr", 32'(bus.mram_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(2'b11, 10'h0C3, 16'h5A3C, 1, 1'b0);

`ifdef RDCTRL_TIMEOUT_EN
    begin
      int rd_cyc, err_k, loads, dones;
      rd_cyc = 0; err_k = -1; loads = 0; dones = 0;
      bus.req = 1'b1;
      bus.req_addr = 10'h077;
      bus.req_word_sel = 2'b11;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        bus.req = 1'b0;
        if (bus.mram_rd_req) rd_cyc++;
        if (bus.err && err_k < 0) err_k = c;
        if (bus.ser_load) loads++;
        if (bus.done) dones++;
        bus.mram_rd_ack = (c == 8);
      end
      bus.mram_rd_ack = 1'b0;
      check("timeout_rd_cycles", rd_cyc, 4);
      check("timeout_err_cycle", err_k, 5);
      check("timeout_no_load", loads, 0);
      check("timeout_no_done", dones, 0);
      check("timeout_late_ack", 32'(bus.busy), 32'd0);
    end
`endif

    for (int i = 0; i < 24; i++) begin
      logic [1:0] sel;
      sel = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      run_frame(sel, ADDR_W'($urandom), 16'($urandom), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mram_readout_ctrl.md
# mram_readout_ctrl

Sequencer for the MRAM read-out path. It accepts a read request (address plus word select), runs the MRAM read handshake, and loads the returned 16-bit word into the downstream parallel-to-serial shifter. It then drives that shifter's shift strobe for exactly 8 or 16 cycles and frames the serial bits with a valid flag and an end-of-frame pulse. It sits between the host-side command logic and the MRAM/shifter pair.

## Interface
- ADDR_W, 10, MRAM word address width
- TIMEOUT_CYC, 255, max READ-state cycles waiting for `mram_rd_ack` (used only with the timeout macro)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  read request, sampled in IDLE only
- req_addr  in  ADDR_W  word address, captured with `req`
- req_word_sel  in  2  11 = full word (16 bits), 01 = lower byte (8 bits), 10 = upper byte (8 bits), 00 = illegal
- busy  out  1  high from the cycle after acceptance until return to IDLE
- done  out  1  one-cycle end-of-frame pulse
- err  out  1  one-cycle pulse on illegal word select or timeout
- mram_rd_req  out  1  read strobe, held until acknowledged
- mram_addr  out  ADDR_W  latched address, stable while `busy`
- mram_rd_ack  in  1  MRAM data valid on shifter `data_in`; must stay stable through the following LOAD cycle
- ser_en  out  1  shifter enable, equal to `busy`
- ser_load  out  1  shifter load strobe
- ser_send  out  1  shifter shift strobe
- ser_word_sel  out  2  latched word select
- bit_valid  out  1  shifter `data_out` holds a valid frame bit this cycle

## Operation
- States: IDLE, READ, LOAD, SHIFT, DONE (plus ERR when timeout is compiled in).
- IDLE:
  - `req`=1 with `req_word_sel`≠00: latch address and word select, go to READ.
  - `req`=1 with `req_word_sel`=00: pulse `err` next cycle, stay in IDLE.
- READ: `mram_rd_req`=1. On `mram_rd_ack`=1, go to LOAD. `mram_rd_req` drops in the same cycle the state changes.
- LOAD: `ser_load`=1 for one cycle. Clear the bit counter. Set N = 16 for word select 11, else N = 8.
- SHIFT: `ser_send`=1 every cycle. The counter counts 0..N−1; after count N−1, go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `bit_valid` is `ser_send` registered by one cycle, matching the shifter's registered output. It stays high through the DONE cycle.
- Ignored inputs:
  - `req` while `busy` is ignored; it is not queued.
  - `mram_rd_ack` outside READ is ignored.
- Reset, including mid-frame: state goes to IDLE; the counter, `busy`, `done`, `err`, `mram_rd_req`, `mram_addr`, `ser_*`, and `bit_valid` all go to 0. The shifter is reset separately.

## Timing
- `req` sampled at cycle 0 → READ and `busy`=1 at cycle 1.
- `mram_rd_ack` sampled at cycle a → LOAD at a+1.
- SHIFT runs from a+2 to a+1+N.
- `bit_valid` is high from a+3 to a+2+N (N cycles).
- DONE at a+2+N, coinciding with the last valid bit.
- IDLE at a+3+N, where a new `req` is accepted.
- Zero-wait ack (a = 1) gives a minimum frame of N+4 cycles from `req` to `done`.
- `busy` has no gaps between back-to-back frames other than the single IDLE cycle.

## Configuration
- RDCTRL_TIMEOUT_EN defined:
  - A counter runs in READ.
  - If `mram_rd_ack` has not arrived after TIMEOUT_CYC cycles, go to ERR. `mram_rd_req` drops, and `err` pulses for one cycle.
  - No `ser_load` and no `done` occur for that request; the state then returns to IDLE.
- RDCTRL_TIMEOUT_EN undefined: READ waits indefinitely. The ERR state and the timeout counter are absent, and `err` is driven only by the illegal-select case.

## Test plan
- Full word: `req` with addr 0x005, select 11, ack after 2 READ cycles, MRAM word 0xA5C3 → `mram_addr`=0x005; `ser_send` high 16 cycles; serial bits 1010010111000011 MSB-first with `bit_valid` high 16 cycles; `done` on the last bit.
- Lower byte: select 01, word 0x12F0 → 8 `ser_send` cycles; bits 11110000; `done` on the 8th valid bit.
- Illegal select and busy request: `req` with select 00 → `err` pulse, `busy` stays 0. A second `req` issued while `busy` → no effect on address or frame length.
- Reset mid-SHIFT: drop `rst_n` at the 5th shift → all outputs 0 immediately; the next `req` starts a clean frame.
- Timeout (macro on, TIMEOUT_CYC=4): no ack → `mram_rd_req` high 4 cycles, then `err` pulse, no `ser_load`; a later ack is ignored.
- Back-to-back: two requests with zero-wait ack → each frame is N+4 cycles from `req` to `done`, with one IDLE cycle between them.
